// File: rtl/fomo_pkg.sv
// Shared types and constants for the VGA fade/dither slice.
package fomo_pkg;

   typedef enum logic [1:0] {
      ST_ON,
      ST_FADE_OUT,
      ST_OFF,
      ST_FADE_IN
   } fade_state_t;

   localparam logic [4:0] FADE_MAX = 5'd16;

   localparam logic [3:0] BAYER_T00 = 4'd0;
   localparam logic [3:0] BAYER_T01 = 4'd2;
   localparam logic [3:0] BAYER_T10 = 4'd3;
   localparam logic [3:0] BAYER_T11 = 4'd1;

   function automatic logic [3:0] bayer_thresh(input logic y0, input logic x0);
      case ({y0, x0})
         2'b00:   bayer_thresh = BAYER_T00;
         2'b01:   bayer_thresh = BAYER_T01;
         2'b10:   bayer_thresh = BAYER_T10;
         default: bayer_thresh = BAYER_T11;
      endcase
   endfunction

endpackage

// File: rtl/vga_bayer2x2.sv
// One colour channel of 2x2 ordered dither: add threshold, saturate at 15, keep top 2 bits.
module vga_bayer2x2
   import fomo_pkg::*;
(
   input  logic [3:0] scaled,
   input  logic       x0,
   input  logic       y0,
   output logic [1:0] chan
);

   logic [4:0] d;
   logic [3:0] d_sat;

   always_comb begin
      d     = {1'b0, scaled} + {1'b0, bayer_thresh(y0, x0)};
      d_sat = d[4] ? 4'hF : d[3:0];
      chan  = d_sat[3:2];
   end

endmodule

// File: rtl/vga_fade_dither.sv
// Two-stage brightness scale + Bayer dither to the TinyVGA PMOD byte.
// Fade FSM is built only when VGA_FADE_EN is defined; otherwise brightness is fixed at full.
module vga_fade_dither
   import fomo_pkg::*;
#(
   parameter int unsigned FADE_STEP = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in_r,
   input  logic [3:0] in_g,
   input  logic [3:0] in_b,
   input  logic       in_hsync,
   input  logic       in_vsync,
   input  logic       in_active,
   input  logic       in_x0,
   input  logic       in_y0,
   input  logic       fade_go,
   output logic [7:0] uo_out,
   output logic [4:0] fade_level,
   output logic       busy
);

   logic [3:0] scaled_r, scaled_g, scaled_b;
   logic [3:0] s1_r, s1_g, s1_b;
   logic       s1_hs, s1_vs, s1_act, s1_x0, s1_y0;
   logic [1:0] dith_r, dith_g, dith_b;

`ifdef VGA_FADE_EN
   localparam logic [4:0] STEP = 5'(FADE_STEP);

   fade_state_t state;
   logic [4:0]  level;
   logic        vsync_q;
   logic        tick;
   logic [8:0]  prod_r, prod_g, prod_b;

   assign tick       = in_vsync & ~vsync_q;
   assign fade_level = level;

   // Level only moves on a frame tick, so a fade_go arriving with a tick just changes state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         state   <= ST_FADE_IN;
         level   <= '0;
         busy    <= 1'b1;
      end else begin
         vsync_q <= in_vsync;
         case (state)
            ST_ON: if (fade_go) begin
               state <= ST_FADE_OUT;
               busy  <= 1'b1;
            end
            ST_OFF: if (fade_go) begin
               state <= ST_FADE_IN;
               busy  <= 1'b1;
            end
            ST_FADE_OUT: if (tick) begin
               if (level <= STEP) begin
                  level <= '0;
                  state <= ST_OFF;
                  busy  <= 1'b0;
               end else begin
                  level <= level - STEP;
               end
            end
            ST_FADE_IN: if (tick) begin
               if (level >= FADE_MAX - STEP) begin
                  level <= FADE_MAX;
                  state <= ST_ON;
                  busy  <= 1'b0;
               end else begin
                  level <= level + STEP;
               end
            end
            default: begin
               state <= ST_FADE_IN;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      prod_r   = {5'b0, in_r} * {4'b0, level};
      prod_g   = {5'b0, in_g} * {4'b0, level};
      prod_b   = {5'b0, in_b} * {4'b0, level};
      scaled_r = 4'(prod_r >> 4);
      scaled_g = 4'(prod_g >> 4);
      scaled_b = 4'(prod_b >> 4);
   end
`else
   logic unused_cfg;

   assign unused_cfg = fade_go ^ (FADE_STEP == 0);
   assign fade_level = FADE_MAX;
   assign busy       = 1'b0;

   always_comb begin
      scaled_r = in_r;
      scaled_g = in_g;
      scaled_b = in_b;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r   <= '0;
         s1_g   <= '0;
         s1_b   <= '0;
         s1_hs  <= 1'b0;
         s1_vs  <= 1'b0;
         s1_act <= 1'b0;
         s1_x0  <= 1'b0;
         s1_y0  <= 1'b0;
      end else begin
         s1_r   <= scaled_r;
         s1_g   <= scaled_g;
         s1_b   <= scaled_b;
         s1_hs  <= in_hsync;
         s1_vs  <= in_vsync;
         s1_act <= in_active;
         s1_x0  <= in_x0;
         s1_y0  <= in_y0;
      end
   end

   vga_bayer2x2 u_bayer_r (.scaled(s1_r), .x0(s1_x0), .y0(s1_y0), .chan(dith_r));
   vga_bayer2x2 u_bayer_g (.scaled(s1_g), .x0(s1_x0), .y0(s1_y0), .chan(dith_g));
   vga_bayer2x2 u_bayer_b (.scaled(s1_b), .x0(s1_x0), .y0(s1_y0), .chan(dith_b));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uo_out <= '0;
      end else if (s1_act) begin
         uo_out <= {s1_hs, dith_b[0], dith_g[0], dith_r[0],
                    s1_vs, dith_b[1], dith_g[1], dith_r[1]};
      end else begin
         uo_out <= {s1_hs, 3'b000, s1_vs, 3'b000};
      end
   end

endmodule

// File: tb/tb_vga_fade_dither.sv
// Directed bench for vga_fade_dither; fade sequences are exercised when VGA_FADE_EN is defined.
module tb_vga_fade_dither;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_r, in_g, in_b;
   logic       in_hsync, in_vsync, in_active, in_x0, in_y0;
   logic       fade_go;
   logic [7:0] uo_out;
   logic [4:0] fade_level;
   logic       busy;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   localparam int NV = 10;
   logic [16:0] vec   [NV];
   logic [7:0]  exp_b [NV];

   vga_fade_dither #(.FADE_STEP(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_r       (in_r),
      .in_g       (in_g),
      .in_b       (in_b),
      .in_hsync   (in_hsync),
      .in_vsync   (in_vsync),
      .in_active  (in_active),
      .in_x0      (in_x0),
      .in_y0      (in_y0),
      .fade_go    (fade_go),
      .uo_out     (uo_out),
      .fade_level (fade_level),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {hs, vs, act, x0, y0, r, g, b}
   function automatic logic [16:0] pv(input logic hs, input logic vs, input logic act,
                                      input logic x0, input logic y0,
                                      input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
      pv = {hs, vs, act, x0, y0, r, g, b};
   endfunction

   task automatic drive(input logic [16:0] v);
      {in_hsync, in_vsync, in_active, in_x0, in_y0, in_r, in_g, in_b} = v;
   endtask

   task automatic tick_check(input string tag, input logic [4:0] lvl, input logic bsy);
      in_vsync = 1'b1;
      step();
      check_val({tag, "_lvl"}, {3'b0, fade_level}, {3'b0, lvl});
      check_val({tag, "_busy"}, {7'b0, busy}, {7'b0, bsy});
      in_vsync = 1'b0;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0] = pv(0,0,1,0,0,4'd15,4'd8,4'd0);   exp_b[0] = 8'h13;
      vec[1] = pv(0,0,1,0,0,4'd0,4'd5,4'd0);    exp_b[1] = 8'h20;
      vec[2] = pv(0,0,1,1,0,4'd0,4'd5,4'd0);    exp_b[2] = 8'h20;
      vec[3] = pv(0,0,1,0,1,4'd0,4'd5,4'd0);    exp_b[3] = 8'h02;
      vec[4] = pv(0,0,1,1,1,4'd0,4'd5,4'd0);    exp_b[4] = 8'h20;
      vec[5] = pv(1,0,0,0,0,4'd15,4'd0,4'd0);   exp_b[5] = 8'h80;
      vec[6] = pv(0,1,0,0,0,4'd15,4'd0,4'd0);   exp_b[6] = 8'h08;
      vec[7] = pv(1,1,0,0,0,4'd15,4'd0,4'd0);   exp_b[7] = 8'h88;
      vec[8] = pv(0,0,1,1,1,4'd15,4'd15,4'd15); exp_b[8] = 8'h77;
      vec[9] = pv(0,0,1,0,0,4'd0,4'd0,4'd12);   exp_b[9] = 8'h44;

      rst_n = 1'b0;
      fade_go = 1'b0;
      drive('0);
      repeat (3) step();
      check_val("rst_uo", uo_out, 8'h00);
      rst_n = 1'b1;
      step();
      check_val("post_rst_uo", uo_out, 8'h00);

`ifdef VGA_FADE_EN
      check_val("post_rst_lvl", {3'b0, fade_level}, 8'd0);
      check_val("post_rst_busy", {7'b0, busy}, 8'd1);
      tick_check("fin1", 5'd4, 1'b1);
      tick_check("fin2", 5'd8, 1'b1);
      tick_check("fin3", 5'd12, 1'b1);
      tick_check("fin4", 5'd16, 1'b0);
`else
      check_val("fixed_lvl", {3'b0, fade_level}, 8'd16);
      check_val("fixed_busy", {7'b0, busy}, 8'd0);
      fade_go = 1'b1;
      step();
      fade_go = 1'b0;
      tick_check("nofade1", 5'd16, 1'b0);
      tick_check("nofade2", 5'd16, 1'b0);
`endif

      for (int i = 0; i <= NV; i++) begin
         if (i < NV) drive(vec[i]);
         else drive('0);
         step();
         if (i >= 1) check_val($sformatf("pix%0d", i - 1), uo_out, exp_b[i - 1]);
      end

`ifdef VGA_FADE_EN
      // fade_go together with a tick in ON: state changes, level holds until the next tick
      fade_go  = 1'b1;
      in_vsync = 1'b1;
      step();
      check_val("go_tick_lvl", {3'b0, fade_level}, 8'd16);
      check_val("go_tick_busy", {7'b0, busy}, 8'd1);
      fade_go  = 1'b0;
      in_vsync = 1'b0;
      step();
      tick_check("fout1", 5'd12, 1'b1);
      fade_go = 1'b1;
      step();
      fade_go = 1'b0;
      check_val("mid_go_lvl", {3'b0, fade_level}, 8'd12);
      check_val("mid_go_busy", {7'b0, busy}, 8'd1);
      tick_check("fout2", 5'd8, 1'b1);
      tick_check("fout3", 5'd4, 1'b1);
      tick_check("fout4", 5'd0, 1'b0);
      tick_check("off_hold", 5'd0, 1'b0);

      fade_go = 1'b1;
      step();
      fade_go = 1'b0;
      check_val("fin_start_busy", {7'b0, busy}, 8'd1);
      tick_check("fin_b1", 5'd4, 1'b1);
      tick_check("fin_b2", 5'd8, 1'b1);

      drive(pv(0,0,1,0,0,4'd15,4'd0,4'd0));
      step();
      step();
      check_val("lvl8_r00", uo_out, 8'h10);
      drive(pv(0,0,1,1,0,4'd15,4'd0,4'd0));
      step();
      step();
      check_val("lvl8_r01", uo_out, 8'h01);
      drive(pv(0,0,1,0,0,4'd15,4'd0,4'd0));
      step();
      step();
      check_val("pre_rst_uo", uo_out, 8'h10);
      #2 rst_n = 1'b0;
      #1;
      check_val("midfade_rst_uo", uo_out, 8'h00);
      check_val("midfade_rst_lvl", {3'b0, fade_level}, 8'd0);
      check_val("midfade_rst_busy", {7'b0, busy}, 8'd1);
      #1 rst_n = 1'b1;
      drive('0);
      step();
      tick_check("refin1", 5'd4, 1'b1);
`else
      drive(pv(0,0,1,0,0,4'd15,4'd0,4'd0));
      step();
      step();
      check_val("pre_rst_uo", uo_out, 8'h11);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst_uo", uo_out, 8'h00);
      #1 rst_n = 1'b1;
      drive('0);
      step();
      step();
      check_val("after_rst_lvl", {3'b0, fade_level}, 8'd16);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
